// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous show-ahead FIFO.
//  - Any power-of-two DEPTH >= 2. All DEPTH entries are usable because each
//    pointer carries one extra wrap bit.
//  - Thresholds: almostFull when numel >= AF_LEVEL, almostEmpty when numel <= AE_LEVEL.
//  - flush synchronously empties the queue and wins over write/read in that cycle.
//  - Optional macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags,
//    which are cleared by clrErr. Without the macro both flags are tied low
//    and clrErr is ignored.
module fifo_param #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     write,
  input  logic [WIDTH-1:0]         writeData,
  input  logic                     read,
  output logic [WIDTH-1:0]         readData,
  output logic [$clog2(DEPTH):0]   numel,
  output logic                     full,
  output logic                     empty,
  output logic                     almostFull,
  output logic                     almostEmpty,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clrErr
);

  localparam int AW = $clog2(DEPTH);   // index width
  localparam int PW = AW + 1;          // pointer width: index plus wrap bit

  localparam logic [PW-1:0] DEPTH_CNT = PW'(DEPTH);
  localparam logic [PW-1:0] AF_CNT    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_CNT    = PW'(AE_LEVEL);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    inAddr;
  logic [PW-1:0]    outAddr;
  logic             wrEn;
  logic             rdEn;

  // Status outputs are decoded from the registered pointers only. The wrap
  // bit lets the modulo difference reach DEPTH, so full and empty never alias.
  assign numel       = inAddr - outAddr;
  assign full        = (numel == DEPTH_CNT);
  assign empty       = (numel == '0);
  assign almostFull  = (numel >= AF_CNT);
  assign almostEmpty = (numel <= AE_CNT);

  // A pop frees a slot in the same cycle, so a write to a full FIFO is
  // accepted when a read is accepted alongside it. On an empty FIFO the read
  // is rejected and the write still goes in.
  assign rdEn = read & ~empty;
  assign wrEn = write & (~full | rdEn);

  // Show-ahead: the head entry is always visible. It is don't-care when empty.
  assign readData = mem[outAddr[AW-1:0]];

  // Storage array: capture accepted writes at the tail slot.
  // NOTE: the data array has no reset. Occupancy comes only from the pointers,
  // so stale contents are never observable, and leaving the array unreset lets
  // it map onto plain RAM or flops without a reset net.
  always_ff @(posedge clk) begin
    if (wrEn && !flush) begin
      mem[inAddr[AW-1:0]] <= writeData;
    end
  end

  // Pointer update: an async reset or a flush empties the queue, and
  // otherwise each accepted transfer advances its pointer.
  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples pre-edge values and the result does not depend on block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inAddr  <= '0;
      outAddr <= '0;
    end else if (flush) begin
      inAddr  <= '0;
      outAddr <= '0;
    end else begin
      if (wrEn) inAddr  <= inAddr + PTR_ONE;
      if (rdEn) outAddr <= outAddr + PTR_ONE;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflowQ;
  logic underflowQ;

  // Sticky error flags: a new error takes priority over clrErr in the same
  // cycle, and flush leaves the flags untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflowQ  <= 1'b0;
      underflowQ <= 1'b0;
    end else begin
      if (write && full && !rdEn) overflowQ <= 1'b1;
      else if (clrErr)            overflowQ <= 1'b0;
      if (read && empty)          underflowQ <= 1'b1;
      else if (clrErr)            underflowQ <= 1'b0;
    end
  end

  assign overflow  = overflowQ;
  assign underflow = underflowQ;
`else
  logic unusedClrErr;
  assign unusedClrErr = clrErr;
  assign overflow     = 1'b0;
  assign underflow    = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed test of fifo_param with WIDTH=16, DEPTH=16,
// AF_LEVEL=12, AE_LEVEL=2. The table covers the fill/overfill/drain run.
// Hand-written sequences cover full-bypass, empty write+read, streaming
// across pointer wrap, flush and asynchronous reset.
module tb_fifo_param;

`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, write, read, clrErr;
  logic [15:0] writeData;
  logic [15:0] readData;
  logic [4:0]  numel;
  logic        full, empty, almostFull, almostEmpty, overflow, underflow;

  int total = 0;
  int bad   = 0;

  fifo_param #(.WIDTH(16), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .write(write), .writeData(writeData),
    .read(read), .readData(readData), .numel(numel), .full(full), .empty(empty),
    .almostFull(almostFull), .almostEmpty(almostEmpty), .overflow(overflow),
    .underflow(underflow), .clrErr(clrErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        wr;
    bit        rd;
    bit [15:0] wd;
    int        expNumel;
    bit [15:0] expData;
    bit        chkData;
    bit        expEmpty;
    bit        expFull;
    bit        expAf;
    bit        expAe;
    bit        expOvf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(bit wr, bit rd, bit [15:0] wd, int n, bit [15:0] d,
                              bit chk, bit ovf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.wd = wd; v.expNumel = n; v.expData = d; v.chkData = chk;
    v.expEmpty = (n == 0); v.expFull = (n == 16);
    v.expAf = (n >= 12); v.expAe = (n <= 2); v.expOvf = ovf;
    return v;
  endfunction

  task automatic push(input logic [15:0] d);
    write = 1'b1; writeData = d;
    tick();
    write = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; write = 1'b0; read = 1'b0; clrErr = 1'b0;
    writeData = '0;

    // Table: 16 writes, a rejected 17th write, then 16 reads in order.
    for (int k = 1; k <= 16; k++) vecs.push_back(mk(1, 0, 16'(k), k, 16'h0001, 1, 0));
    vecs.push_back(mk(1, 0, 16'hDEAD, 16, 16'h0001, 1, ERR));
    for (int k = 1; k <= 16; k++) vecs.push_back(mk(0, 1, 16'h0, 16 - k, 16'(k + 1), k < 16, ERR));

    // Reset state.
    #2;
    check("rst numel", numel, 0);
    check("rst empty", empty, 1);
    check("rst full", full, 0);
    check("rst almostEmpty", almostEmpty, 1);
    check("rst almostFull", almostFull, 0);
    check("rst overflow", overflow, 0);
    check("rst underflow", underflow, 0);
    tick();
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      write = vecs[i].wr; read = vecs[i].rd; writeData = vecs[i].wd;
      tick();
      write = 1'b0; read = 1'b0;
      check($sformatf("vec%0d numel", i), numel, vecs[i].expNumel);
      check($sformatf("vec%0d empty", i), empty, vecs[i].expEmpty);
      check($sformatf("vec%0d full", i), full, vecs[i].expFull);
      check($sformatf("vec%0d almostFull", i), almostFull, vecs[i].expAf);
      check($sformatf("vec%0d almostEmpty", i), almostEmpty, vecs[i].expAe);
      check($sformatf("vec%0d overflow", i), overflow, vecs[i].expOvf);
      if (vecs[i].chkData) check($sformatf("vec%0d readData", i), readData, vecs[i].expData);
    end

    // Clear the sticky overflow.
    clrErr = 1'b1; tick(); clrErr = 1'b0;
    check("clr overflow", overflow, 0);

    // Full FIFO with a simultaneous write and read: both are accepted.
    for (int k = 1; k <= 16; k++) push(16'h0100 + 16'(k));
    check("bypass prefull", full, 1);
    write = 1'b1; writeData = 16'h00AA; read = 1'b1;
    tick();
    write = 1'b0; read = 1'b0;
    check("bypass numel", numel, 16);
    check("bypass overflow", overflow, 0);
    for (int k = 2; k <= 16; k++) begin
      check($sformatf("bypass head%0d", k), readData, 16'h0100 + 16'(k));
      read = 1'b1; tick(); read = 1'b0;
    end
    check("bypass last", readData, 16'h00AA);
    read = 1'b1; tick(); read = 1'b0;
    check("bypass drained", empty, 1);

    // Empty FIFO with a simultaneous write and read: only the write is accepted.
    write = 1'b1; writeData = 16'h1234; read = 1'b1;
    tick();
    write = 1'b0; read = 1'b0;
    check("ewr numel", numel, 1);
    check("ewr data", readData, 16'h1234);
    check("ewr underflow", underflow, 0);
    read = 1'b1; tick();            // pop 0x1234
    check("ewr empty", empty, 1);
    tick(); read = 1'b0;            // read while empty
    check("underflow set", underflow, ERR);
    check("underflow numel", numel, 0);
    clrErr = 1'b1; tick(); clrErr = 1'b0;
    check("underflow clr", underflow, 0);

    // Stream 40 words through a 3-deep prefill. The pointers wrap repeatedly.
    for (int k = 0; k < 3; k++) push(16'h2000 + 16'(k));
    for (int k = 0; k < 40; k++) begin
      check($sformatf("stream head%0d", k), readData, 16'h2000 + 16'(k));
      write = 1'b1; writeData = 16'h2003 + 16'(k); read = 1'b1;
      tick();
      check($sformatf("stream numel%0d", k), numel, 3);
    end
    write = 1'b0;
    for (int k = 40; k < 43; k++) begin
      check($sformatf("stream tail%0d", k), readData, 16'h2000 + 16'(k));
      tick();
    end
    read = 1'b0;
    check("stream empty", empty, 1);

    // Flush overrides a concurrent write and read.
    for (int k = 0; k < 7; k++) push(16'h3000 + 16'(k));
    check("preflush numel", numel, 7);
    flush = 1'b1; write = 1'b1; writeData = 16'h3FFF; read = 1'b1;
    tick();
    flush = 1'b0; write = 1'b0; read = 1'b0;
    check("flush numel", numel, 0);
    check("flush empty", empty, 1);

    // Asynchronous reset in the middle of a write burst.
    for (int k = 0; k < 5; k++) push(16'h4000 + 16'(k));
    write = 1'b1; writeData = 16'h4005;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst empty", empty, 1);
    check("arst numel", numel, 0);
    write = 1'b0;
    tick();
    rst_n = 1'b1;
    push(16'h5555);
    check("post-rst numel", numel, 1);
    check("post-rst data", readData, 16'h5555);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
